// File: rtl/trade_pkg.sv
// Shared types and sizing for the stock-game trade datapath.
package trade_pkg;

    localparam int PRICE_W = 12;
    localparam int QTY_W   = 8;
    localparam int CASH_W  = 24;
    localparam int HOLD_2S = 100_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MUL_A,
        ST_MUL_C,
        ST_COMMIT,
        ST_HOLD,
        ST_ERROR
    } sell_state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Serial shift-add multiplier accumulating mcand*mplier into acc over B_W cycles.
module shift_add_multiplier #(
    parameter int A_W   = 12,
    parameter int B_W   = 8,
    parameter int ACC_W = 25
) (
    input  logic             clock_50,
    input  logic             resetn,
    input  logic             start,
    input  logic             load_acc,
    input  logic [A_W-1:0]   mcand,
    input  logic [B_W-1:0]   mplier,
    input  logic [ACC_W-1:0] acc_init,
    output logic [ACC_W-1:0] acc,
    output logic             done
);

    localparam int CW = (B_W > 1) ? $clog2(B_W) : 1;

    logic [ACC_W-1:0] mcand_sh;
    logic [B_W-1:0]   b_sh;
    logic [CW-1:0]    cnt;
    logic             running;

    assign done = running && (cnt == CW'(B_W - 1));

    // A start on the final step edge reloads operands while that step still
    // lands in acc, so back-to-back products chain without a gap cycle.
    always_ff @(posedge clock_50) begin
        if (!resetn) begin
            acc      <= '0;
            mcand_sh <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            running  <= 1'b0;
        end else begin
            if (running) begin
                if (b_sh[0])
                    acc <= acc + mcand_sh;
                mcand_sh <= mcand_sh << 1;
                b_sh     <= b_sh >> 1;
                cnt      <= cnt + CW'(1);
                if (done)
                    running <= 1'b0;
            end
            if (load_acc)
                acc <= acc_init;
            if (start) begin
                mcand_sh <= {{(ACC_W - A_W){1'b0}}, mcand};
                b_sh     <= mplier;
                cnt      <= '0;
                running  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sell_transaction_controller.sv
// Sell transaction sequencer: validate, multiply-accumulate both stocks, commit, status window.
module sell_transaction_controller
    import trade_pkg::*;
#(
    parameter logic [CASH_W-1:0] INIT_CASH   = 24'h000100,
    parameter logic [QTY_W-1:0]  INIT_QTY    = 8'h0A,
    parameter int unsigned       HOLD_CYCLES = HOLD_2S
) (
    input  logic               clock_50,
    input  logic               resetn,
    input  logic               sell_req,
    input  logic [PRICE_W-1:0] stockA_price,
    input  logic [PRICE_W-1:0] stockC_price,
    input  logic [QTY_W-1:0]   stockA_sold,
    input  logic [QTY_W-1:0]   stockC_sold,
    output logic               sell_ack,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               status_hold,
    output logic [CASH_W-1:0]  current_cash,
    output logic [QTY_W-1:0]   stockA_qty,
    output logic [QTY_W-1:0]   stockC_qty
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int          ACC_W = CASH_W + 1;

    sell_state_t        state, next_state;
    logic [PRICE_W-1:0] snap_a_price, snap_c_price;
    logic [QTY_W-1:0]   snap_a_sold, snap_c_sold;
    logic [CNT_W-1:0]   hold_cnt;
    logic               mul_start, mul_load, mul_sel_c, mul_done;
    logic [ACC_W-1:0]   acc;
    logic               entering_window;

    shift_add_multiplier #(
        .A_W   (PRICE_W),
        .B_W   (QTY_W),
        .ACC_W (ACC_W)
    ) u_mul (
        .clock_50 (clock_50),
        .resetn   (resetn),
        .start    (mul_start),
        .load_acc (mul_load),
        .mcand    (mul_sel_c ? snap_c_price : snap_a_price),
        .mplier   (mul_sel_c ? snap_c_sold : snap_a_sold),
        .acc_init ({1'b0, current_cash}),
        .acc      (acc),
        .done     (mul_done)
    );

    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        mul_load   = 1'b0;
        mul_sel_c  = 1'b0;
        case (state)
            ST_IDLE:   if (sell_req) next_state = ST_CHECK;
            ST_CHECK: begin
                if (snap_a_sold > stockA_qty || snap_c_sold > stockC_qty) begin
                    next_state = ST_ERROR;
                end else begin
                    next_state = ST_MUL_A;
                    mul_start  = 1'b1;
                    mul_load   = 1'b1;
                end
            end
            ST_MUL_A: begin
                if (mul_done) begin
                    next_state = ST_MUL_C;
                    mul_start  = 1'b1;
                    mul_sel_c  = 1'b1;
                end
            end
            ST_MUL_C:  if (mul_done) next_state = ST_COMMIT;
            ST_COMMIT: next_state = ST_HOLD;
            ST_HOLD,
            ST_ERROR:  if (hold_cnt == '0) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign entering_window = (next_state == ST_HOLD || next_state == ST_ERROR) && (next_state != state);

    always_ff @(posedge clock_50) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            sell_ack     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            status_hold  <= 1'b0;
            current_cash <= INIT_CASH;
            stockA_qty   <= INIT_QTY;
            stockC_qty   <= INIT_QTY;
            snap_a_price <= '0;
            snap_c_price <= '0;
            snap_a_sold  <= '0;
            snap_c_sold  <= '0;
            hold_cnt     <= '0;
        end else begin
            state       <= next_state;
            sell_ack    <= (state == ST_CHECK);
            busy        <= (next_state != ST_IDLE);
            done        <= (state == ST_COMMIT);
            error       <= (next_state == ST_ERROR);
            status_hold <= (next_state == ST_HOLD || next_state == ST_ERROR);

            if (state == ST_IDLE && sell_req) begin
                snap_a_price <= stockA_price;
                snap_c_price <= stockC_price;
                snap_a_sold  <= stockA_sold;
                snap_c_sold  <= stockC_sold;
            end

            if (state == ST_COMMIT) begin
                current_cash <= acc[CASH_W] ? '1 : acc[CASH_W-1:0];
                stockA_qty   <= stockA_qty - snap_a_sold;
                stockC_qty   <= stockC_qty - snap_c_sold;
            end

            if (entering_window)
                hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_sell_transaction_controller.sv
// Directed bench for the sell transaction controller with a 4-cycle status window.
module tb_sell_transaction_controller;
    import trade_pkg::*;

    logic               clock_50 = 1'b0;
    logic               resetn, sell_req, sell_req2;
    logic [PRICE_W-1:0] pa, pc;
    logic [QTY_W-1:0]   sa, sc;

    logic              ack, busy, done, error, status_hold;
    logic [CASH_W-1:0] cash;
    logic [QTY_W-1:0]  qa, qc;
    logic              ack2, busy2, done2, error2, status_hold2;
    logic [CASH_W-1:0] cash2;
    logic [QTY_W-1:0]  qa2, qc2;

    int checks = 0;
    int errors = 0;

    always #5 clock_50 = ~clock_50;

    sell_transaction_controller #(
        .INIT_CASH   (24'h000100),
        .INIT_QTY    (8'h0A),
        .HOLD_CYCLES (4)
    ) dut (
        .clock_50 (clock_50), .resetn (resetn), .sell_req (sell_req),
        .stockA_price (pa), .stockC_price (pc), .stockA_sold (sa), .stockC_sold (sc),
        .sell_ack (ack), .busy (busy), .done (done), .error (error), .status_hold (status_hold),
        .current_cash (cash), .stockA_qty (qa), .stockC_qty (qc)
    );

    sell_transaction_controller #(
        .INIT_CASH   (24'hFFF000),
        .INIT_QTY    (8'h0A),
        .HOLD_CYCLES (4)
    ) dut_sat (
        .clock_50 (clock_50), .resetn (resetn), .sell_req (sell_req2),
        .stockA_price (pa), .stockC_price (pc), .stockA_sold (sa), .stockC_sold (sc),
        .sell_ack (ack2), .busy (busy2), .done (done2), .error (error2), .status_hold (status_hold2),
        .current_cash (cash2), .stockA_qty (qa2), .stockC_qty (qc2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        sell_req  = 1'b0;
        sell_req2 = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Leaves the bench just after E0, the edge that samples the request.
    task automatic start_sale();
        sell_req = 1'b1;
        tick();
        sell_req = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic count_hold(output int n);
        n = 0;
        while (status_hold && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int lat, n, errcnt, donecnt;
        int acks, ack1, ack2c, dones, done1, done2c;
        logic [CASH_W-1:0] cash1;

        pa = '0; pc = '0; sa = '0; sc = '0;
        do_reset();
        check_val("reset_cash", cash, 24'h000100);
        check_val("reset_qa", qa, 8'h0A);
        check_val("reset_qc", qc, 8'h0A);
        check_val("reset_flags", {ack, busy, done, error, status_hold}, 5'b0);

        // Normal sale: 0x100 + 0x10*5 + 3*2 = 0x156
        pa = 12'h010; pc = 12'h003; sa = 8'd5; sc = 8'd2;
        start_sale();
        check_val("t1_busy_e0", busy, 1);
        check_val("t1_ack_e0", ack, 0);
        tick();
        check_val("t1_ack_e1", ack, 1);
        wait_done(1, lat);
        check_val("t1_done_lat", lat, 18);
        check_val("t1_cash", cash, 24'h000156);
        check_val("t1_qa", qa, 8'h05);
        check_val("t1_qc", qc, 8'h08);
        count_hold(n);
        check_val("t1_hold_len", n, 4);
        check_val("t1_idle_busy", busy, 0);

        // Oversell
        do_reset();
        sa = 8'h0B; sc = 8'h00;
        start_sale();
        tick();
        check_val("t2_ack", ack, 1);
        check_val("t2_err_hold", {error, status_hold}, 2'b11);
        errcnt = 0; donecnt = 0;
        for (int i = 0; i < 10; i++) begin
            errcnt += int'(error);
            donecnt += int'(done);
            tick();
        end
        check_val("t2_err_len", errcnt, 4);
        check_val("t2_no_done", donecnt, 0);
        check_val("t2_cash", cash, 24'h000100);
        check_val("t2_qty", {qa, qc}, 16'h0A0A);

        // Saturation on the high-cash instance
        do_reset();
        pa = 12'hFFF; pc = 12'hFFF; sa = 8'h0A; sc = 8'h0A;
        sell_req2 = 1'b1;
        tick();
        sell_req2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 60) begin
            tick();
            lat++;
        end
        check_val("t3_done_lat", lat, 18);
        check_val("t3_cash_sat", cash2, 24'hFFFFFF);
        check_val("t3_qty", {qa2, qc2}, 16'h0000);

        // Reset during MUL_C
        do_reset();
        pa = 12'h010; pc = 12'h003; sa = 8'd5; sc = 8'd2;
        start_sale();
        for (int i = 0; i < 11; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_val("t4_flags", {ack, busy, done, error, status_hold}, 5'b0);
        check_val("t4_cash", cash, 24'h000100);
        check_val("t4_qty", {qa, qc}, 16'h0A0A);
        for (int i = 0; i < 25; i++) tick();
        check_val("t4_no_late_commit", cash, 24'h000100);

        // Snapshot, dropped mid-sale request, held request re-triggers after HOLD
        do_reset();
        pa = 12'h010; pc = 12'h003; sa = 8'd5; sc = 8'd2;
        start_sale();
        acks = 0; ack1 = 0; ack2c = 0; dones = 0; done1 = 0; done2c = 0; cash1 = '0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 3) begin
                pa = 12'h100;
                sell_req = 1'b1;
            end
            if (ack) begin
                acks++;
                if (acks == 1) ack1 = k;
                else begin
                    ack2c = k;
                    sell_req = 1'b0;
                end
            end
            if (done) begin
                if (dones == 0) begin
                    done1 = k;
                    cash1 = cash;
                end else done2c = k;
                dones++;
            end
        end
        sell_req = 1'b0;
        check_val("t5_acks", acks, 2);
        check_val("t5_ack1", ack1, 1);
        check_val("t5_done1", done1, 18);
        check_val("t5_cash1", cash1, 24'h000156);
        check_val("t5_ack2", ack2c, 24);
        check_val("t5_done2", done2c, 41);
        check_val("t5_cash2", cash, 24'h00065C);
        check_val("t5_qty", {qa, qc}, 16'h0006);
        check_val("t5_idle", busy, 0);

        // Zero sale
        do_reset();
        pa = 12'h123; pc = 12'h456; sa = 8'd0; sc = 8'd0;
        start_sale();
        wait_done(0, lat);
        check_val("t6_done_lat", lat, 18);
        check_val("t6_cash", cash, 24'h000100);
        check_val("t6_qty", {qa, qc}, 16'h0A0A);
        count_hold(n);
        check_val("t6_hold_len", n, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
